// File: rtl/pipeline_collector.sv
// Collects results of the 5-stage pipeline into a small FIFO by delaying a copy of
// the launch strobe, and presents them on a valid/ready stream with overflow accounting.
module pipeline_collector #(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 5,
    parameter int DEPTH   = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     SET,
    input  logic [WIDTH-1:0]         PIPE_OUT,
    output logic [WIDTH-1:0]         OUT_DATA,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     OVERFLOW,
    output logic [7:0]               DROPS
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [LATENCY-1:0] tag;
    logic [WIDTH-1:0]   mem [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [CW-1:0]      count;
    logic               capture;
    logic               pop;
    logic               push;
    logic               drop;

    // A pop frees the slot in the same edge, so a full FIFO still accepts a capture.
    always_comb begin
        capture = tag[LATENCY-1];
        pop     = (count != '0) && OUT_READY;
        push    = capture && ((count != FULL_COUNT) || pop);
        drop    = capture && (count == FULL_COUNT) && !pop;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            tag      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            OVERFLOW <= 1'b0;
            DROPS    <= '0;
        end else begin
            tag <= LATENCY'({tag, SET});
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
            if (drop) begin
                OVERFLOW <= 1'b1;
                if (DROPS != '1) begin
                    DROPS <= DROPS + 8'd1;
                end
            end
        end
    end

    // Storage needs no reset; the pointers and count define which entries are live.
    always_ff @(posedge CLK) begin
        if (push && !RST) begin
            mem[wr_ptr] <= PIPE_OUT;
        end
    end

    assign OUT_VALID = (count != '0);
    assign OUT_DATA  = OUT_VALID ? mem[rd_ptr] : '0;
    assign COUNT     = count;

endmodule

// File: tb/tb_pipeline_collector.sv
// Bench for pipeline_collector: an ideal 5-stage pipeline model drives PIPE_OUT, a
// queue-based reference model is compared every cycle, plus directed tables/sequences.
module tb_pipeline_collector;

    localparam int LAT   = 5;
    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic       set;
    logic [7:0] in_val;
    logic [7:0] pipe_out;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] count;
    logic       overflow;
    logic [7:0] drops;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    pipeline_collector #(.WIDTH(8), .LATENCY(LAT), .DEPTH(DEPTH)) dut (
        .CLK      (clk),
        .RST      (rst),
        .SET      (set),
        .PIPE_OUT (pipe_out),
        .OUT_DATA (out_data),
        .OUT_VALID(out_valid),
        .OUT_READY(out_ready),
        .COUNT    (count),
        .OVERFLOW (overflow),
        .DROPS    (drops)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] f(input logic [7:0] x);
        int t;
        t = 2 * int'(x) * int'(x) + 2;
        return t[7:0];
    endfunction

    // Ideal upstream pipeline: the operand sampled at edge k is visible after edge k+4.
    logic [7:0] stg [LAT];
    always @(posedge clk) begin
        stg[0] <= in_val;
        for (int unsigned i = 1; i < LAT; i++) stg[i] <= stg[i-1];
    end
    assign pipe_out = f(stg[LAT-1]);

    // Reference model: launches carry a due edge; the FIFO is a plain queue.
    typedef struct {
        int         due;
        logic [7:0] val;
    } flight_t;
    flight_t    inflight[$];
    logic [7:0] mq[$];
    bit         m_ovf;
    int         m_drops;
    logic [7:0] popped[$];

    task automatic model_edge(input bit r, input bit s, input logic [7:0] i, input bit rdy);
        bit         rd;
        bit         cap;
        logic [7:0] v;
        cyc++;
        if (r) begin
            inflight.delete();
            mq.delete();
            m_ovf   = 1'b0;
            m_drops = 0;
        end else begin
            rd  = (mq.size() > 0) && rdy;
            cap = (inflight.size() > 0) && (inflight[0].due == cyc);
            if (rd) void'(mq.pop_front());
            if (cap) begin
                v = inflight[0].val;
                void'(inflight.pop_front());
                if (mq.size() < DEPTH) mq.push_back(v);
                else begin
                    m_ovf = 1'b1;
                    if (m_drops < 255) m_drops++;
                end
            end
            if (s) inflight.push_back('{due: cyc + LAT, val: f(i)});
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic compare_model();
        bit ev;
        ev = mq.size() > 0;
        check("model_valid", int'(out_valid), int'(ev));
        check("model_data", int'(out_data), ev ? int'(mq[0]) : 0);
        check("model_count", int'(count), mq.size());
        check("model_overflow", int'(overflow), int'(m_ovf));
        check("model_drops", int'(drops), m_drops);
    endtask

    task automatic tick(input bit r, input bit s, input logic [7:0] i, input bit rdy);
        rst       = r;
        set       = s;
        in_val    = i;
        out_ready = rdy;
        if (!r && out_valid && rdy) popped.push_back(out_data);
        @(posedge clk);
        model_edge(r, s, i, rdy);
        #1;
        compare_model();
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int unsigned k = 0; k < n; k++) tick(1'b0, 1'b0, 8'd0, rdy);
    endtask

    task automatic do_reset();
        tick(1'b1, 1'b0, 8'd0, 1'b1);
        tick(1'b1, 1'b0, 8'd0, 1'b1);
    endtask

    task automatic check_popped(input string name, input logic [7:0] exp[$]);
        check({name, "_len"}, popped.size(), exp.size());
        for (int unsigned k = 0; k < exp.size() && k < popped.size(); k++)
            check({name, "_val"}, int'(popped[k]), int'(exp[k]));
        popped.delete();
    endtask

    typedef struct {
        bit         rst;
        bit         set;
        logic [7:0] in;
        bit         rdy;
        bit         ev;
        logic [7:0] ed;
        int         ec;
        bit         eo;
        int         edr;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(input bit r, input bit s, input int i, input bit rdy,
                                input bit ev, input int ed, input int ec, input bit eo,
                                input int edr);
        vec_t v;
        v.rst = r; v.set = s; v.in = i[7:0]; v.rdy = rdy;
        v.ev = ev; v.ed = ed[7:0]; v.ec = ec; v.eo = eo; v.edr = edr;
        tbl.push_back(v);
    endfunction

    initial begin
        logic [7:0] exp_q[$];
        int         vcnt;
        int         pct;

        // Single launch (IN=2) then backpressure/overflow with IN=2..7.
        add(1, 0, 0, 1, 0,  0, 0, 0, 0);
        add(1, 0, 0, 1, 0,  0, 0, 0, 0);
        add(0, 1, 2, 1, 0,  0, 0, 0, 0);
        for (int unsigned k = 0; k < 4; k++) add(0, 0, 0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 1, 10, 1, 0, 0);
        add(0, 0, 0, 1, 0,  0, 0, 0, 0);
        for (int unsigned k = 2; k <= 6; k++) add(0, 1, int'(k), 0, 0, 0, 0, 0, 0);
        add(0, 1, 7, 0, 1, 10, 1, 0, 0);
        add(0, 0, 0, 0, 1, 10, 2, 0, 0);
        add(0, 0, 0, 0, 1, 10, 3, 0, 0);
        add(0, 0, 0, 0, 1, 10, 4, 0, 0);
        add(0, 0, 0, 0, 1, 10, 4, 1, 1);
        add(0, 0, 0, 0, 1, 10, 4, 1, 2);
        add(0, 0, 0, 1, 1, 20, 3, 1, 2);
        add(0, 0, 0, 1, 1, 34, 2, 1, 2);
        add(0, 0, 0, 1, 1, 52, 1, 1, 2);
        add(0, 0, 0, 1, 0,  0, 0, 1, 2);

        rst = 1'b1; set = 1'b0; in_val = '0; out_ready = 1'b1;
        for (int unsigned k = 0; k < tbl.size(); k++) begin
            tick(tbl[k].rst, tbl[k].set, tbl[k].in, tbl[k].rdy);
            check("tbl_valid", int'(out_valid), int'(tbl[k].ev));
            check("tbl_data", int'(out_data), int'(tbl[k].ed));
            check("tbl_count", int'(count), tbl[k].ec);
            check("tbl_overflow", int'(overflow), int'(tbl[k].eo));
            check("tbl_drops", int'(drops), tbl[k].edr);
        end
        popped.delete();

        // Streamed burst IN=2..9 with the consumer always ready.
        do_reset();
        for (int unsigned k = 2; k <= 9; k++) tick(1'b0, 1'b1, 8'(k), 1'b1);
        idle(8, 1'b1);
        exp_q = '{8'd10, 8'd20, 8'd34, 8'd52, 8'd74, 8'd100, 8'd130, 8'd164};
        check_popped("burst", exp_q);
        check("burst_overflow", int'(overflow), 0);
        check("burst_drops", int'(drops), 0);

        // Full FIFO with a read and a write on the same edge.
        do_reset();
        exp_q = '{8'd2, 8'd3, 8'd4, 8'd5, 8'd8, 8'd9};
        for (int unsigned k = 0; k < 6; k++) tick(1'b0, 1'b1, exp_q[k], 1'b0);
        idle(3, 1'b0);
        check("full_count", int'(count), 4);
        tick(1'b0, 1'b0, 8'd0, 1'b1);
        check("rw_count1", int'(count), 4);
        check("rw_drops1", int'(drops), 0);
        tick(1'b0, 1'b0, 8'd0, 1'b1);
        check("rw_count2", int'(count), 4);
        check("rw_drops2", int'(drops), 0);
        idle(6, 1'b1);
        exp_q = '{8'd10, 8'd20, 8'd34, 8'd52, 8'd130, 8'd164};
        check_popped("rw_order", exp_q);

        // Reset mid-burst; SET at the reset edge is lost, SET right after is kept.
        do_reset();
        vcnt = 0;
        for (int unsigned k = 2; k <= 4; k++) begin
            tick(1'b0, 1'b1, 8'(k), 1'b1);
            vcnt += int'(out_valid);
        end
        tick(1'b1, 1'b1, 8'd7, 1'b1);
        check("midrst_count", int'(count), 0);
        check("midrst_overflow", int'(overflow), 0);
        tick(1'b0, 1'b1, 8'd5, 1'b1);
        vcnt += int'(out_valid);
        for (int unsigned k = 0; k < 4; k++) begin
            tick(1'b0, 1'b0, 8'd0, 1'b1);
            vcnt += int'(out_valid);
        end
        check("midrst_no_valid", vcnt, 0);
        tick(1'b0, 1'b0, 8'd0, 1'b1);
        check("midrst_valid", int'(out_valid), 1);
        check("midrst_data", int'(out_data), 52);
        idle(8, 1'b1);
        exp_q = '{8'd52};
        check_popped("midrst_order", exp_q);

        // Single launch then a long gap with PIPE_OUT holding the same result.
        do_reset();
        tick(1'b0, 1'b1, 8'd3, 1'b0);
        for (int unsigned k = 0; k < 10; k++) tick(1'b0, 1'b0, 8'd3, 1'b0);
        check("gap_count", int'(count), 1);
        check("gap_data", int'(out_data), 20);
        idle(3, 1'b1);
        popped.delete();

        // Drop counter saturation.
        do_reset();
        for (int unsigned k = 0; k < 270; k++) tick(1'b0, 1'b1, 8'(k), 1'b0);
        idle(LAT, 1'b0);
        check("drops_saturate", int'(drops), 255);
        check("sat_overflow", int'(overflow), 1);

        // Randomized traffic with occasional resets and varying backpressure.
        do_reset();
        for (int unsigned k = 0; k < 1200; k++) begin
            case ((k / 150) % 4)
                0: pct = 90;
                1: pct = 30;
                2: pct = 0;
                default: pct = 60;
            endcase
            tick($urandom_range(0, 79) == 0, $urandom_range(0, 2) != 0,
                 8'($urandom_range(0, 255)), $urandom_range(0, 99) < pct);
        end
        popped.delete();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
